// File: rtl/apb_bank_master.sv
// apb_bank_master: two-port round-robin APB master for the GPIO expander register banks.
// Port A and port B requests are arbitrated, then one SETUP/ACCESS transfer is run
// with a one-hot bank select; completion is a one-cycle ack with err and read data.
// Define APB_TIMEOUT_EN to abort an ACCESS phase after TIMEOUT_CYCLES cycles without pready.
module apb_bank_master #(
    parameter int BANK_ADDR      = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 3,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [BANK_ADDR-1:0]  a_bank,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_err,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [BANK_ADDR-1:0]  b_bank,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_err,
    output logic [BANK_ADDR-1:0]  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

    state_e                state_q, state_d;
    logic                  gnt_q, gnt_d;     // port being served: 0 = A, 1 = B
    logic                  last_q, last_d;   // last granted port, loses the next tie
    logic                  wr_q, wr_d;
    logic [BANK_ADDR-1:0]  bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  done_err;         // err reported by the completion being entered

    logic [BANK_ADDR-1:0]  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic                  a_err_q, a_err_d, b_err_q, b_err_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                  bus_on;
    logic                  rd_cap;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]      cnt_q, cnt_d;
`endif

    // State register and latched command
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            bank_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wr_q    <= wr_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef APB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Next state: arbitration and command capture in IDLE, transfer sequencing after
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        wr_d     = wr_q;
        bank_d   = bank_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_err = 1'b0;
`ifdef APB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (a_req || b_req) begin
                    gnt_d   = (a_req && b_req) ? ~last_q : b_req;
                    last_d  = gnt_d;
                    wr_d    = gnt_d ? b_write : a_write;
                    bank_d  = gnt_d ? b_bank  : a_bank;
                    addr_d  = gnt_d ? b_addr  : a_addr;
                    wdata_d = gnt_d ? b_wdata : a_wdata;
                    if ($onehot(bank_d)) begin
                        state_d = SETUP;
                    end else begin
                        state_d  = DONE;
                        done_err = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    state_d = DONE;
`ifdef APB_TIMEOUT_EN
                // cnt_q counts completed waiting cycles, so this edge makes it TIMEOUT_CYCLES
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = DONE;
                    done_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output next values, derived from the state being entered so every output is registered
    always_comb begin
        bus_on    = (state_d == SETUP) || (state_d == ACCESS);
        psel_d    = bus_on ? bank_d : '0;
        penable_d = (state_d == ACCESS);
        pwrite_d  = bus_on & wr_d;
        paddr_d   = bus_on ? addr_d  : '0;
        pwdata_d  = bus_on ? wdata_d : '0;
        a_ack_d   = (state_d == DONE) && !gnt_d;
        b_ack_d   = (state_d == DONE) &&  gnt_d;
        a_err_d   = a_ack_d ? done_err : a_err_q;
        b_err_d   = b_ack_d ? done_err : b_err_q;
        rd_cap    = (state_q == ACCESS) && pready && !wr_q;
        a_rdata_d = (rd_cap && !gnt_q) ? prdata : a_rdata_q;
        b_rdata_d = (rd_cap &&  gnt_q) ? prdata : b_rdata_q;
    end

    // Output registers
    always_ff @(posedge pclk) begin
        if (preset) begin
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_err_q   <= 1'b0;
            b_err_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_err_q   <= a_err_d;
            b_err_q   <= b_err_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_err   = a_err_q;
    assign b_err   = b_err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_apb_bank_master.sv
// tb_apb_bank_master: directed and randomized checks of apb_bank_master against a
// behavioural model (round-robin winner, per-port expected read data, fixed latencies).
module tb_apb_bank_master;
    localparam int BA = 2;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          preset;
    logic          a_req, a_write, b_req, b_write;
    logic [BA-1:0] a_bank, b_bank;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_wdata, b_wdata;
    logic          a_ack, a_err, b_ack, b_err;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [BA-1:0] psel;
    logic          penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          pready;

    int            n_cmp = 0;
    int            n_err = 0;
    logic          model_last;           // last granted port: 0 = A, 1 = B
    logic [DW-1:0] exp_ardata, exp_brdata;

    always #5 pclk = ~pclk;

    apb_bank_master #(
        .BANK_ADDR(BA), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk(pclk), .preset(preset),
        .a_req(a_req), .a_write(a_write), .a_bank(a_bank), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_write(b_write), .b_bank(b_bank), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready)
    );

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [1:0] rand_bank();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 2'b00;
        if (r == 1) return 2'b11;
        return (r % 2 == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic test_reset();
        preset = 1'b1;
        a_req = 1'b0; a_write = 1'b0; a_bank = '0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_write = 1'b0; b_bank = '0; b_addr = '0; b_wdata = '0;
        pready = 1'b0; prdata = '0;
        step(); step();
        n_cmp++;
        if ({psel, penable, pwrite} !== 4'b0) begin
            n_err++; $display("FAIL reset_bus_ctl: got psel=%b penable=%b pwrite=%b want 0", psel, penable, pwrite);
        end
        n_cmp++;
        if ({paddr, pwdata} !== 11'b0) begin
            n_err++; $display("FAIL reset_bus_data: got paddr=%h pwdata=%h want 0", paddr, pwdata);
        end
        n_cmp++;
        if ({a_ack, a_err, b_ack, b_err} !== 4'b0) begin
            n_err++; $display("FAIL reset_ack_err: got %b want 0000", {a_ack, a_err, b_ack, b_err});
        end
        n_cmp++;
        if ({a_rdata, b_rdata} !== 16'h0) begin
            n_err++; $display("FAIL reset_rdata: got a=%h b=%h want 0", a_rdata, b_rdata);
        end
        preset = 1'b0;
        model_last = 1'b1; exp_ardata = '0; exp_brdata = '0;
        step();
        n_cmp++;
        if ({psel, penable, a_ack, b_ack} !== 5'b0) begin
            n_err++; $display("FAIL reset_release_idle: got psel=%b penable=%b acks=%b%b want 0", psel, penable, a_ack, b_ack);
        end
    endtask

    task automatic test_round_robin();
        logic order[$];
        int   when[$];
        logic exp_w;
        int   c;
        bit   done;
        a_req = 1'b1; a_write = 1'b1; a_bank = 2'b01; a_addr = 3'h1; a_wdata = 8'h11;
        b_req = 1'b1; b_write = 1'b0; b_bank = 2'b10; b_addr = 3'h6; b_wdata = 8'h22;
        pready = 1'b1; prdata = 8'h3C;
        c = 0; done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            step(); c++;
            n_cmp++;
            if (a_ack && b_ack) begin
                n_err++; $display("FAIL rr_overlap: got both acks at cycle %0d want at most one", c);
            end
            if (a_ack || b_ack) begin
                order.push_back(b_ack);
                when.push_back(c);
                if (order.size() == 6) begin
                    a_req = 1'b0; b_req = 1'b0; done = 1;
                end
            end
        end
        n_cmp++;
        if (!done) begin
            n_err++; $display("FAIL rr_budget: got %0d acks want 6", order.size());
        end
        step();
        n_cmp++;
        if (when.size() > 0 && when[0] != 3) begin
            n_err++; $display("FAIL rr_first_latency: got %0d want 3", when[0]);
        end
        for (int k = 0; k < order.size(); k++) begin
            exp_w = ~model_last;
            model_last = exp_w;
            if (exp_w) exp_brdata = 8'h3C;
            n_cmp++;
            if (order[k] !== exp_w) begin
                n_err++; $display("FAIL rr_order[%0d]: got port %0d want port %0d", k, order[k], exp_w);
            end
            if (k > 0) begin
                n_cmp++;
                if (when[k] - when[k-1] != 4) begin
                    n_err++; $display("FAIL rr_spacing[%0d]: got %0d want 4", k, when[k] - when[k-1]);
                end
            end
        end
        n_cmp++;
        if ({a_rdata, b_rdata} !== {exp_ardata, exp_brdata}) begin
            n_err++; $display("FAIL rr_rdata: got a=%h b=%h want a=%h b=%h", a_rdata, b_rdata, exp_ardata, exp_brdata);
        end
    endtask

    task automatic test_write_a();
        a_req = 1'b1; a_write = 1'b1; a_bank = 2'b01; a_addr = 3'h5; a_wdata = 8'hA5;
        pready = 1'b1; prdata = 8'h77;
        step();
        n_cmp++;
        if ({psel, penable, pwrite, paddr, pwdata, a_ack} !== {2'b01, 1'b0, 1'b1, 3'h5, 8'hA5, 1'b0}) begin
            n_err++; $display("FAIL wr_setup: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h ack=%b want 01 0 1 5 a5 0",
                              psel, penable, pwrite, paddr, pwdata, a_ack);
        end
        a_write = 1'b0; a_bank = 2'b10; a_addr = 3'h2; a_wdata = 8'h5A;
        step();
        n_cmp++;
        if ({psel, penable, pwrite, paddr, pwdata, a_ack} !== {2'b01, 1'b1, 1'b1, 3'h5, 8'hA5, 1'b0}) begin
            n_err++; $display("FAIL wr_access: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h ack=%b want 01 1 1 5 a5 0",
                              psel, penable, pwrite, paddr, pwdata, a_ack);
        end
        step();
        n_cmp++;
        if ({a_ack, a_err, b_ack, psel, penable} !== {1'b1, 1'b0, 1'b0, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL wr_done: got a_ack=%b a_err=%b b_ack=%b psel=%b pen=%b want 1 0 0 00 0",
                              a_ack, a_err, b_ack, psel, penable);
        end
        n_cmp++;
        if (a_rdata !== exp_ardata) begin
            n_err++; $display("FAIL wr_rdata_kept: got %h want %h", a_rdata, exp_ardata);
        end
        a_req = 1'b0; model_last = 1'b0;
        step();
        n_cmp++;
        if ({a_ack, psel, penable} !== 4'b0) begin
            n_err++; $display("FAIL wr_after: got a_ack=%b psel=%b pen=%b want 0", a_ack, psel, penable);
        end
    endtask

    task automatic test_read_b_wait();
        b_req = 1'b1; b_write = 1'b0; b_bank = 2'b10; b_addr = 3'h2; b_wdata = 8'h00;
        pready = 1'b0; prdata = 8'h00;
        step();
        n_cmp++;
        if ({psel, penable, pwrite, paddr} !== {2'b10, 1'b0, 1'b0, 3'h2}) begin
            n_err++; $display("FAIL rd_setup: got psel=%b pen=%b pw=%b paddr=%h want 10 0 0 2", psel, penable, pwrite, paddr);
        end
        b_addr = 3'h7; b_write = 1'b1;
        pready = 1'b1; prdata = 8'hEE;
        step();
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({psel, penable, pwrite, paddr, b_ack} !== {2'b10, 1'b1, 1'b0, 3'h2, 1'b0}) begin
                n_err++; $display("FAIL rd_access[%0d]: got psel=%b pen=%b pw=%b paddr=%h ack=%b want 10 1 0 2 0",
                                  i, psel, penable, pwrite, paddr, b_ack);
            end
            if (i == 3) begin
                pready = 1'b1; prdata = 8'hF9;
            end else begin
                pready = 1'b0; prdata = 8'($urandom);
            end
            step();
        end
        n_cmp++;
        if ({b_ack, b_err, b_rdata} !== {1'b1, 1'b0, 8'hF9}) begin
            n_err++; $display("FAIL rd_done: got b_ack=%b b_err=%b b_rdata=%h want 1 0 f9", b_ack, b_err, b_rdata);
        end
        n_cmp++;
        if ({a_ack, a_rdata, psel, penable} !== {1'b0, exp_ardata, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL rd_other: got a_ack=%b a_rdata=%h psel=%b pen=%b want 0 %h 00 0",
                              a_ack, a_rdata, psel, penable, exp_ardata);
        end
        exp_brdata = 8'hF9; model_last = 1'b1;
        b_req = 1'b0; pready = 1'b1;
        step();
    endtask

    task automatic test_invalid_bank();
        for (int i = 0; i < 2; i++) begin
            a_req = 1'b1; a_write = 1'b0; a_bank = (i == 0) ? 2'b00 : 2'b11;
            a_addr = 3'($urandom); pready = 1'b1; prdata = 8'hC3;
            step();
            n_cmp++;
            if ({a_ack, a_err, b_ack, psel, penable} !== {1'b1, 1'b1, 1'b0, 2'b00, 1'b0}) begin
                n_err++; $display("FAIL inv_done[%0d]: got a_ack=%b a_err=%b b_ack=%b psel=%b pen=%b want 1 1 0 00 0",
                                  i, a_ack, a_err, b_ack, psel, penable);
            end
            n_cmp++;
            if (a_rdata !== exp_ardata) begin
                n_err++; $display("FAIL inv_rdata[%0d]: got %h want %h", i, a_rdata, exp_ardata);
            end
            a_req = 1'b0; model_last = 1'b0;
            step();
            n_cmp++;
            if ({a_ack, psel, penable} !== 4'b0) begin
                n_err++; $display("FAIL inv_after[%0d]: got a_ack=%b psel=%b pen=%b want 0", i, a_ack, psel, penable);
            end
        end
    endtask

    task automatic test_random();
        logic          ra, rb, win, inv;
        logic          ca_w, cb_w, w_w;
        logic [1:0]    ca_bank, cb_bank, w_bank;
        logic [2:0]    ca_addr, cb_addr, w_addr;
        logic [7:0]    ca_wd, cb_wd, w_wd, rv;
        int            wt, acc, c, exp_lat;
        bit            got;
        for (int t = 0; t < 60; t++) begin
            ra = 1'($urandom_range(0, 1)); rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1'b1;
            ca_w = 1'($urandom_range(0, 1)); ca_bank = rand_bank(); ca_addr = 3'($urandom); ca_wd = 8'($urandom);
            cb_w = 1'($urandom_range(0, 1)); cb_bank = rand_bank(); cb_addr = 3'($urandom); cb_wd = 8'($urandom);
            a_req = ra; a_write = ca_w; a_bank = ca_bank; a_addr = ca_addr; a_wdata = ca_wd;
            b_req = rb; b_write = cb_w; b_bank = cb_bank; b_addr = cb_addr; b_wdata = cb_wd;
            win = (ra && rb) ? ~model_last : rb;
            model_last = win;
            w_w = win ? cb_w : ca_w; w_bank = win ? cb_bank : ca_bank;
            w_addr = win ? cb_addr : ca_addr; w_wd = win ? cb_wd : ca_wd;
            inv = !(w_bank == 2'b01 || w_bank == 2'b10);
            wt = int'($urandom_range(0, 3)); rv = 8'($urandom);
            pready = 1'($urandom_range(0, 1)); prdata = 8'($urandom);
            c = 0; acc = 0; got = 0;
            for (int i = 0; i < 30 && !got; i++) begin
                step(); c++;
                if (i == 0) begin
                    a_write = 1'($urandom); a_bank = 2'($urandom); a_addr = 3'($urandom); a_wdata = 8'($urandom);
                    b_write = 1'($urandom); b_bank = 2'($urandom); b_addr = 3'($urandom); b_wdata = 8'($urandom);
                end
                if (a_ack || b_ack) begin
                    got = 1;
                end else begin
                    n_cmp++;
                    if (inv || c > 2 + wt ||
                        {psel, pwrite, paddr, pwdata} !== {w_bank, w_w, w_addr, w_wd} || penable !== (c > 1)) begin
                        n_err++; $display("FAIL rand_bus[%0d] cyc %0d: got psel=%b pen=%b pw=%b paddr=%h pwdata=%h want %b %b %b %h %h",
                                          t, c, psel, penable, pwrite, paddr, pwdata, w_bank, (c > 1), w_w, w_addr, w_wd);
                    end
                    if (penable) begin
                        pready = (acc == wt);
                        prdata = (acc == wt) ? rv : 8'($urandom);
                        acc++;
                    end else begin
                        pready = 1'($urandom_range(0, 1)); prdata = 8'($urandom);
                    end
                end
            end
            exp_lat = inv ? 1 : 3 + wt;
            if (!inv && !w_w) begin
                if (win) exp_brdata = rv; else exp_ardata = rv;
            end
            n_cmp++;
            if (!got || c != exp_lat) begin
                n_err++; $display("FAIL rand_latency[%0d]: got ack=%0d at %0d want ack at %0d", t, got, c, exp_lat);
            end
            n_cmp++;
            if ({a_ack, b_ack} !== (win ? 2'b01 : 2'b10)) begin
                n_err++; $display("FAIL rand_ack_port[%0d]: got a=%b b=%b want port %0d", t, a_ack, b_ack, win);
            end
            n_cmp++;
            if ((win ? b_err : a_err) !== inv) begin
                n_err++; $display("FAIL rand_err[%0d]: got %b want %b", t, (win ? b_err : a_err), inv);
            end
            n_cmp++;
            if ({a_rdata, b_rdata} !== {exp_ardata, exp_brdata}) begin
                n_err++; $display("FAIL rand_rdata[%0d]: got a=%h b=%h want a=%h b=%h", t, a_rdata, b_rdata, exp_ardata, exp_brdata);
            end
            a_req = 1'b0; b_req = 1'b0;
            step();
            n_cmp++;
            if ({psel, penable, a_ack, b_ack} !== 5'b0) begin
                n_err++; $display("FAIL rand_idle[%0d]: got psel=%b pen=%b acks=%b%b want 0", t, psel, penable, a_ack, b_ack);
            end
        end
        pready = 1'b1;
    endtask

    task automatic test_timeout();
        int n_acc;
        bit got;
        a_req = 1'b1; a_write = 1'b0; a_bank = 2'b01; a_addr = 3'h3; a_wdata = 8'h00;
        pready = 1'b0; prdata = 8'h99;
        step(); step();
`ifdef APB_TIMEOUT_EN
        n_acc = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (a_ack) got = 1;
            else begin
                if (penable) n_acc++;
                step();
            end
        end
        n_cmp++;
        if (!got || n_acc != TO) begin
            n_err++; $display("FAIL to_cycles: got ack=%0d after %0d ACCESS cycles want ack after %0d", got, n_acc, TO);
        end
        n_cmp++;
        if ({a_err, a_rdata, psel, penable} !== {1'b1, exp_ardata, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL to_done: got err=%b rdata=%h psel=%b pen=%b want 1 %h 00 0", a_err, a_rdata, psel, penable, exp_ardata);
        end
        a_req = 1'b0; model_last = 1'b0;
        step();
        a_req = 1'b1;
        step(); step();
        for (int i = 0; i < TO; i++) begin
            if (i == TO - 1) begin
                pready = 1'b1; prdata = 8'h4B;
            end
            step();
        end
        n_cmp++;
        if ({a_ack, a_err, a_rdata} !== {1'b1, 1'b0, 8'h4B}) begin
            n_err++; $display("FAIL to_limit_pready: got ack=%b err=%b rdata=%h want 1 0 4b", a_ack, a_err, a_rdata);
        end
        exp_ardata = 8'h4B;
        a_req = 1'b0; pready = 1'b0;
        step();
`else
        got = 0; n_acc = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_ack) got = 1;
            if (penable) n_acc++;
            step();
        end
        n_cmp++;
        if (got || n_acc != 100 || {psel, penable} !== 3'b011) begin
            n_err++; $display("FAIL noto_wait: got ack=%0d access=%0d psel=%b pen=%b want 0 100 01 1", got, n_acc, psel, penable);
        end
        pready = 1'b1; prdata = 8'h4B;
        step();
        n_cmp++;
        if ({a_ack, a_err, a_rdata} !== {1'b1, 1'b0, 8'h4B}) begin
            n_err++; $display("FAIL noto_done: got ack=%b err=%b rdata=%h want 1 0 4b", a_ack, a_err, a_rdata);
        end
        exp_ardata = 8'h4B; model_last = 1'b0;
        a_req = 1'b0;
        step();
`endif
        pready = 1'b1;
    endtask

    task automatic test_reset_mid();
        b_req = 1'b1; b_write = 1'b0; b_bank = 2'b10; b_addr = 3'h1;
        pready = 1'b0; prdata = 8'hD2;
        step(); step(); step();
        preset = 1'b1; pready = 1'b1;
        a_req = 1'b1; a_write = 1'b1; a_bank = 2'b01; a_addr = 3'h4; a_wdata = 8'h6D;
        step();
        n_cmp++;
        if ({psel, penable, pwrite, paddr, pwdata, a_ack, b_ack, a_err, b_err} !== 19'b0) begin
            n_err++; $display("FAIL rst_mid_out: got psel=%b pen=%b b_ack=%b a_ack=%b want 0", psel, penable, b_ack, a_ack);
        end
        n_cmp++;
        if ({a_rdata, b_rdata} !== 16'h0) begin
            n_err++; $display("FAIL rst_mid_rdata: got a=%h b=%h want 0", a_rdata, b_rdata);
        end
        exp_ardata = '0; exp_brdata = '0; model_last = 1'b1;
        preset = 1'b0;
        step();
        n_cmp++;
        if ({psel, pwrite, paddr} !== {2'b01, 1'b1, 3'h4}) begin
            n_err++; $display("FAIL rst_mid_first: got psel=%b pw=%b paddr=%h want 01 1 4", psel, pwrite, paddr);
        end
        step(); step();
        n_cmp++;
        if ({a_ack, b_ack} !== 2'b10) begin
            n_err++; $display("FAIL rst_mid_a_ack: got a=%b b=%b want 1 0", a_ack, b_ack);
        end
        a_req = 1'b0; model_last = 1'b0;
        step(); step(); step(); step();
        n_cmp++;
        if ({b_ack, b_err, b_rdata} !== {1'b1, 1'b0, 8'hD2}) begin
            n_err++; $display("FAIL rst_mid_b_after: got ack=%b err=%b rdata=%h want 1 0 d2", b_ack, b_err, b_rdata);
        end
        b_req = 1'b0; model_last = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_write_a();
        test_read_b_wait();
        test_invalid_bank();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
